mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter MEM_HANDSHAKE, default 1, meaning: 1 makes memory states wait on mem_ready; 0 ignores mem_ready and treats it as 1.
REQ-002 Parameter HAS_UPPER, default 1, meaning: 1 enables lui, auipc and jalr; 0 treats those opcodes as illegal.
REQ-003 Parameter CNT_W, default 32, meaning: width of the retired-instruction counter.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 op  input  7  opcode of the instruction register.
REQ-007 funct3  input  3  instruction funct3.
REQ-008 zero  input  1  ALU zero flag from the current cycle.
REQ-009 mem_ready  input  1  memory-access-complete strobe.
REQ-010 pcwrite, adrsrc, irwrite, memwrite, regwrite  output  1 each  PC load, address select (0=PC, 1=result), IR load, memory write, register-file write.
REQ-011 resultsrc, alusrca, alusrcb, aluop  output  2 each  mux selects and ALU-op class.
REQ-012 immsrc  output  3  immediate format: I=000, S=001, B=010, J=011, U=100.
REQ-013 illegal  output  1  sticky illegal-opcode flag.
REQ-014 instret  output  CNT_W  retired-instruction count.

Function
REQ-015 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP.
REQ-016 Outputs are a combinational Moore decode of state, except pcwrite and the mem_ready-qualified strobes.
REQ-017 FETCH: adrsrc=0, alusrca=00 (PC), alusrcb=10 (+4), aluop=00, resultsrc=10; irwrite and pcwrite are asserted only in the cycle mem_ready=1; the FSM goes to DECODE on that cycle and otherwise stays in FETCH.
REQ-018 DECODE: alusrca=01 (oldPC), alusrcb=01 (imm), immsrc=010; the FSM branches on op as follows: 0000011/0100011 -> MEMADR, 0110011 -> EXECUTER, 0010011 -> EXECUTEI, 1100011 -> BRANCH, 1101111 -> JAL, 1100111 -> JALR, 0110111 -> LUI, 0010111 -> AUIPC, any other opcode -> TRAP.
REQ-019 MEMADR: alusrca=10, alusrcb=01, immsrc=000 for a load and 001 for a store; the FSM then goes to MEMREAD for a load and MEMWRITE for a store.
REQ-020 MEMREAD: resultsrc=00, adrsrc=1; the FSM waits for mem_ready, then goes to MEMWB.
REQ-021 MEMWRITE: adrsrc=1; memwrite is asserted each cycle until and including the mem_ready cycle; the FSM then goes to FETCH.
REQ-022 MEMWB: resultsrc=01, regwrite=1; the FSM then goes to FETCH.
REQ-023 EXECUTER: alusrca=10, alusrcb=00, aluop=10; EXECUTEI: alusrca=10, alusrcb=01, aluop=10, immsrc=000; both go to ALUWB.
REQ-024 ALUWB: resultsrc=00, regwrite=1; the FSM then goes to FETCH.
REQ-025 BRANCH: alusrca=10, alusrcb=00, aluop=01, resultsrc=00; pcwrite = zero XOR funct3[0] (beq/bne); the FSM then goes to FETCH.
REQ-026 JAL: alusrca=01, alusrcb=10, resultsrc=00, pcwrite=1; the FSM then goes to ALUWB.
REQ-027 JALR: alusrca=10, alusrcb=01, immsrc=000, pcwrite=1; the FSM then goes to ALUWB.
REQ-028 LUI: alusrca=11 (zero), alusrcb=01, immsrc=100; AUIPC: alusrca=01, alusrcb=01, immsrc=100; both go to ALUWB.
REQ-029 TRAP: all write enables are 0, illegal=1; the FSM stays in TRAP until reset.
REQ-030 instret increments by 1 on each transition into FETCH from any non-FETCH state, wraps modulo 2^CNT_W, and does not increment on entry to TRAP.
REQ-031 In every state, any enable not listed for that state is 0 and any select not listed is 0.

Reset
REQ-032 Asserting reset forces state=FETCH, instret=0 and illegal=0 asynchronously.
REQ-033 While reset is high, pcwrite, irwrite, memwrite and regwrite are 0 regardless of state.
REQ-034 Reset asserted mid-instruction aborts that instruction with no write enable pulsed, and instret does not count it.

Structure
REQ-035 Package mc_ctrl_pkg holds the state_t enum, the opcode constants, the immsrc/alusrca/alusrcb/resultsrc encodings and the aluop classes.
REQ-036 One sub-module, mc_state_decoder, provides the combinational state-to-control-vector decode; the next-state logic and the counter are kept in mc_control_fsm.

Verification
REQ-037 Verification scenario, add with mem_ready tied to 1: state sequence FETCH, DECODE, EXECUTER, ALUWB, FETCH; regwrite=1 for exactly 1 cycle; instret 0->1.
REQ-038 Verification scenario, lw with mem_ready low for 3 cycles in MEMREAD: FSM stays 4 cycles in MEMREAD; regwrite is asserted only in MEMWB.
REQ-039 Verification scenario, bne with zero=1, then with zero=0: pcwrite is 0 in BRANCH for the first and 1 for the second.
REQ-040 Verification scenario, op=0000000: FSM is in TRAP after DECODE; illegal=1 persists for 100 cycles; instret is unchanged; reset clears illegal.
REQ-041 Verification scenario, HAS_UPPER=0 with op=0110111: FSM goes to TRAP; with HAS_UPPER=1, lui writes the U-immediate with alusrca=11.
REQ-042 Verification scenario, CNT_W=4: after 16 retired instructions instret=0; reset pulsed mid-MEMWRITE gives no memwrite after the edge and instret=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control FSM:
// states, opcodes, mux-select encodings and the per-state control vector.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LUI,
    S_AUIPC,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // fetch/branch/jump are raw intents; the top qualifies them into pcwrite/irwrite
  typedef struct packed {
    logic       adrsrc;
    logic       memwrite;
    logic       regwrite;
    logic       fetch;
    logic       branch;
    logic       jump;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [2:0] immsrc;
  } ctrl_t;

endpackage

// File: rtl/mc_state_decoder.sv
// Combinational Moore decode of FSM state into the datapath control vector.
module mc_state_decoder
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   is_store,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.fetch     = 1'b1;
        ctrl.alusrca   = SRCA_PC;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.aluop     = ALUOP_ADD;
        ctrl.resultsrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ctrl.alusrca = SRCA_OLDPC;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.immsrc  = IMM_B;
      end
      S_MEMADR: begin
        ctrl.alusrca = SRCA_RS1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.immsrc  = is_store ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.adrsrc    = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adrsrc   = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_MEMWB: begin
        ctrl.resultsrc = RES_DATA;
        ctrl.regwrite  = 1'b1;
      end
      S_EXECR: begin
        ctrl.alusrca = SRCA_RS1;
        ctrl.alusrcb = SRCB_RS2;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl.alusrca = SRCA_RS1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_FUNCT;
        ctrl.immsrc  = IMM_I;
      end
      S_ALUWB: begin
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.regwrite  = 1'b1;
      end
      S_BRANCH: begin
        ctrl.branch    = 1'b1;
        ctrl.alusrca   = SRCA_RS1;
        ctrl.alusrcb   = SRCB_RS2;
        ctrl.aluop     = ALUOP_SUB;
        ctrl.resultsrc = RES_ALUOUT;
      end
      S_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.alusrca   = SRCA_OLDPC;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALUOUT;
      end
      S_JALR: begin
        ctrl.jump    = 1'b1;
        ctrl.alusrca = SRCA_RS1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.immsrc  = IMM_I;
      end
      S_LUI: begin
        ctrl.alusrca = SRCA_ZERO;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.immsrc  = IMM_U;
      end
      S_AUIPC: begin
        ctrl.alusrca = SRCA_OLDPC;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.immsrc  = IMM_U;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control unit: next-state logic, handshake-qualified
// strobes, sticky illegal-opcode flag and retired-instruction counter.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int HAS_UPPER     = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             adrsrc,
  output logic             irwrite,
  output logic             memwrite,
  output logic             regwrite,
  output logic [1:0]       resultsrc,
  output logic [1:0]       alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [2:0]       immsrc,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t           state_q, state_next;
  ctrl_t            ctrl;
  logic             illegal_q;
  logic [CNT_W-1:0] instret_q;
  logic             ready, upper_ok, is_store, take_branch, retire;
  logic             unused_funct3;

  assign ready         = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign upper_ok      = (HAS_UPPER != 0);
  assign is_store      = (op == OP_STORE);
  assign take_branch   = zero ^ funct3[0];
  assign unused_funct3 = ^funct3[2:1];

  mc_state_decoder u_dec (
    .state    (state_q),
    .is_store (is_store),
    .ctrl     (ctrl)
  );

  always_comb begin
    state_next = state_q;
    case (state_q)
      S_FETCH:    if (ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = upper_ok ? S_JALR  : S_TRAP;
          OP_LUI:            state_next = upper_ok ? S_LUI   : S_TRAP;
          OP_AUIPC:          state_next = upper_ok ? S_AUIPC : S_TRAP;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR:   state_next = is_store ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (ready) state_next = S_MEMWB;
      S_MEMWRITE: if (ready) state_next = S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH: state_next = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_JALR, S_LUI, S_AUIPC: state_next = S_ALUWB;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_TRAP;
    endcase
  end

  // An instruction retires on the edge that returns the FSM to FETCH
  assign retire = (state_q != S_FETCH) && (state_next == S_FETCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_next;
      if (state_next == S_TRAP) illegal_q <= 1'b1;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Write strobes are forced low while reset is held, whatever the state
  assign pcwrite  = ~reset & ((ctrl.fetch & ready) | (ctrl.branch & take_branch) | ctrl.jump);
  assign irwrite  = ~reset & ctrl.fetch & ready;
  assign memwrite = ~reset & ctrl.memwrite;
  assign regwrite = ~reset & ctrl.regwrite;

  assign adrsrc    = ctrl.adrsrc;
  assign resultsrc = ctrl.resultsrc;
  assign alusrca   = ctrl.alusrca;
  assign alusrcb   = ctrl.alusrcb;
  assign aluop     = ctrl.aluop;
  assign immsrc    = ctrl.immsrc;
  assign illegal   = illegal_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: default build, a HAS_UPPER=0 build
// and a CNT_W=4 build share one stimulus stream.
module tb_mc_control_fsm;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic pcwrite, adrsrc, irwrite, memwrite, regwrite, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb, aluop;
  logic [2:0] immsrc;
  logic [31:0] instret;

  logic n_pcwrite, n_adrsrc, n_irwrite, n_memwrite, n_regwrite, n_illegal;
  logic [1:0] n_resultsrc, n_alusrca, n_alusrcb, n_aluop;
  logic [2:0] n_immsrc;
  logic [31:0] n_instret;

  logic c_pcwrite, c_adrsrc, c_irwrite, c_memwrite, c_regwrite, c_illegal;
  logic [1:0] c_resultsrc, c_alusrca, c_alusrcb, c_aluop;
  logic [2:0] c_immsrc;
  logic [3:0] c_instret;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .adrsrc(adrsrc), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .immsrc(immsrc),
    .illegal(illegal), .instret(instret)
  );

  mc_control_fsm #(.HAS_UPPER(0)) dut_nu (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(n_pcwrite), .adrsrc(n_adrsrc), .irwrite(n_irwrite), .memwrite(n_memwrite),
    .regwrite(n_regwrite), .resultsrc(n_resultsrc), .alusrca(n_alusrca), .alusrcb(n_alusrcb),
    .aluop(n_aluop), .immsrc(n_immsrc), .illegal(n_illegal), .instret(n_instret)
  );

  mc_control_fsm #(.CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(c_pcwrite), .adrsrc(c_adrsrc), .irwrite(c_irwrite), .memwrite(c_memwrite),
    .regwrite(c_regwrite), .resultsrc(c_resultsrc), .alusrca(c_alusrca), .alusrcb(c_alusrcb),
    .aluop(c_aluop), .immsrc(c_immsrc), .illegal(c_illegal), .instret(c_instret)
  );

  typedef struct packed {
    logic       pcw, adr, irw, memw, regw;
    logic [1:0] res, a, b, aop;
    logic [2:0] imm;
    logic       ill;
  } vec_t;

  typedef struct {
    state_t      st;
    vec_t        v;
    logic [31:0] ret;
    logic        nu_ill;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_ret = 0;
  logic        nu_ill = 1'b0;

  // Expected Moore outputs per state, written out from the control table
  function automatic vec_t model(state_t st, logic rdy, logic z, logic [2:0] f3,
                                 logic store, logic rst);
    vec_t v = '0;
    case (st)
      S_FETCH:    begin v.b = 2'b10; v.res = 2'b10; v.irw = rdy; v.pcw = rdy; end
      S_DECODE:   begin v.a = 2'b01; v.b = 2'b01; v.imm = 3'b010; end
      S_MEMADR:   begin v.a = 2'b10; v.b = 2'b01; v.imm = store ? 3'b001 : 3'b000; end
      S_MEMREAD:  begin v.adr = 1'b1; end
      S_MEMWRITE: begin v.adr = 1'b1; v.memw = 1'b1; end
      S_MEMWB:    begin v.res = 2'b01; v.regw = 1'b1; end
      S_EXECR:    begin v.a = 2'b10; v.aop = 2'b10; end
      S_EXECI:    begin v.a = 2'b10; v.b = 2'b01; v.aop = 2'b10; end
      S_ALUWB:    begin v.regw = 1'b1; end
      S_BRANCH:   begin v.a = 2'b10; v.aop = 2'b01; v.pcw = z ^ f3[0]; end
      S_JAL:      begin v.a = 2'b01; v.b = 2'b10; v.pcw = 1'b1; end
      S_JALR:     begin v.a = 2'b10; v.b = 2'b01; v.pcw = 1'b1; end
      S_LUI:      begin v.a = 2'b11; v.b = 2'b01; v.imm = 3'b100; end
      S_AUIPC:    begin v.a = 2'b01; v.b = 2'b01; v.imm = 3'b100; end
      S_TRAP:     begin v.ill = 1'b1; end
      default:    v = '0;
    endcase
    if (rst) begin v.pcw = 0; v.irw = 0; v.memw = 0; v.regw = 0; end
    return v;
  endfunction

  // One clock of stimulus: drive inputs, push the expectation, advance
  task automatic cyc(input state_t st, input logic rdy, input logic z, input logic rst = 1'b0);
    exp_t e;
    reset = rst;
    mem_ready = rdy;
    zero = z;
    if (rst) begin exp_ret = 0; nu_ill = 1'b0; end
    e.st = st;
    e.v = model(st, rdy, z, funct3, op == 7'b0100011, rst);
    e.ret = exp_ret;
    e.nu_ill = nu_ill;
    sbq.push_back(e);
    @(posedge clk); #1;
    if (!rst && (st == S_ALUWB || st == S_MEMWB || st == S_BRANCH || (st == S_MEMWRITE && rdy)))
      exp_ret = exp_ret + 1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    vec_t act;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      act = {pcwrite, adrsrc, irwrite, memwrite, regwrite, resultsrc, alusrca, alusrcb,
             aluop, immsrc, illegal};
      n_checks++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL ctrl[%s] got %h want %h", e.st.name(), act, e.v);
      end
      n_checks++;
      if (instret !== e.ret) begin
        n_fail++;
        $display("FAIL instret[%s] got %0d want %0d", e.st.name(), instret, e.ret);
      end
      n_checks++;
      if (c_instret !== e.ret[3:0]) begin
        n_fail++;
        $display("FAIL instret_w4[%s] got %0d want %0d", e.st.name(), c_instret, e.ret[3:0]);
      end
      n_checks++;
      if (n_illegal !== e.nu_ill) begin
        n_fail++;
        $display("FAIL illegal_noupper[%s] got %b want %b", e.st.name(), n_illegal, e.nu_ill);
      end
    end
  end

  task automatic ins_add();
    op = 7'b0110011; funct3 = 3'b000;
    cyc(S_FETCH, 1, 0); cyc(S_DECODE, 1, 0); cyc(S_EXECR, 1, 0); cyc(S_ALUWB, 1, 0);
  endtask

  task automatic ins_branch(input logic [2:0] f3, input logic z);
    op = 7'b1100011; funct3 = f3;
    cyc(S_FETCH, 1, z); cyc(S_DECODE, 1, z); cyc(S_BRANCH, 1, z);
  endtask

  task automatic ins_upper(input logic [6:0] opc, input state_t st);
    op = opc; funct3 = 3'b000;
    cyc(S_FETCH, 1, 0); cyc(S_DECODE, 1, 0);
    nu_ill = 1'b1;
    cyc(st, 1, 0); cyc(S_ALUWB, 1, 0);
  endtask

  initial begin
    @(posedge clk); #1;
    cyc(S_FETCH, 1, 0, 1);
    cyc(S_FETCH, 0, 0);
    cyc(S_FETCH, 0, 0);
    ins_add();
    // lw with three not-ready cycles in MEMREAD
    op = 7'b0000011; funct3 = 3'b010;
    cyc(S_FETCH, 1, 0); cyc(S_DECODE, 1, 0); cyc(S_MEMADR, 1, 0);
    cyc(S_MEMREAD, 0, 0); cyc(S_MEMREAD, 0, 0); cyc(S_MEMREAD, 0, 0);
    cyc(S_MEMREAD, 1, 0); cyc(S_MEMWB, 1, 0);
    // sw with one wait cycle
    op = 7'b0100011;
    cyc(S_FETCH, 1, 0); cyc(S_DECODE, 1, 0); cyc(S_MEMADR, 1, 0);
    cyc(S_MEMWRITE, 0, 0); cyc(S_MEMWRITE, 1, 0);
    ins_branch(3'b001, 1);
    ins_branch(3'b001, 0);
    ins_branch(3'b000, 1);
    ins_branch(3'b000, 0);
    op = 7'b0010011; funct3 = 3'b000;
    cyc(S_FETCH, 1, 0); cyc(S_DECODE, 1, 0); cyc(S_EXECI, 1, 0); cyc(S_ALUWB, 1, 0);
    op = 7'b1101111;
    cyc(S_FETCH, 1, 0); cyc(S_DECODE, 1, 0); cyc(S_JAL, 1, 0); cyc(S_ALUWB, 1, 0);
    ins_upper(7'b0110111, S_LUI);
    ins_upper(7'b0010111, S_AUIPC);
    ins_upper(7'b1100111, S_JALR);
    cyc(S_FETCH, 1, 0, 1);
    for (int i = 0; i < 16; i++) ins_add();
    cyc(S_FETCH, 0, 0);
    // illegal opcode: trap holds for 100 cycles until reset
    op = 7'b0000000;
    cyc(S_FETCH, 1, 0); cyc(S_DECODE, 1, 0);
    nu_ill = 1'b1;
    for (int i = 0; i < 100; i++) cyc(S_TRAP, i[0], i[1]);
    cyc(S_FETCH, 1, 0, 1);
    cyc(S_FETCH, 0, 0);
    ins_add();
    // reset asserted in the middle of a store
    op = 7'b0100011;
    cyc(S_FETCH, 1, 0); cyc(S_DECODE, 1, 0); cyc(S_MEMADR, 1, 0); cyc(S_MEMWRITE, 0, 0);
    cyc(S_FETCH, 0, 0, 1);
    cyc(S_FETCH, 0, 0);
    ins_add();
    cyc(S_FETCH, 0, 0);
    for (int g = 0; g < 10 && sbq.size() > 0; g++) @(posedge clk);
    if (sbq.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain got %0d pending want 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
